// File: rtl/vshift_pkg.sv
// Shared definitions for the multi-jump vector element shifter.
// Holds the sequencer state encoding, a constant-evaluable clog2 helper and the
// default geometry used by the shifter and its barrel stage.
package vshift_pkg;

  // Sequencer states: IDLE waits for work, SHIFT walks the remaining distance.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default geometry; lane i of a packed vector sits at bits [i*WIDTH +: WIDTH].
  localparam int DEF_NUMLANES = 8;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_MAXJUMP  = 2;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/velmshift_step.sv
// Combinational barrel stage: moves whole lanes by i_step (0..MAXJUMP) in one go.
// Ports:
//   i_data      packed NUMLANES x WIDTH input vector
//   i_step      lanes to move this cycle
//   i_dirLeft   1 = toward higher lanes, 0 = toward lower lanes
//   i_rotate    1 = wrap vacated lanes from the far end, 0 = use fill values
//   i_fillLeft  value entering the top lanes on a right move
//   i_fillRight value entering the bottom lanes on a left move
//   o_shifted   moved vector
module velmshift_step
  import vshift_pkg::*;
#(
  parameter int NUMLANES = DEF_NUMLANES,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AMTBITS  = clog2(DEF_NUMLANES)
) (
  input  logic [NUMLANES*WIDTH-1:0] i_data,
  input  logic [AMTBITS-1:0]        i_step,
  input  logic                      i_dirLeft,
  input  logic                      i_rotate,
  input  logic [WIDTH-1:0]          i_fillLeft,
  input  logic [WIDTH-1:0]          i_fillRight,
  output logic [NUMLANES*WIDTH-1:0] o_shifted
);

  // Each output lane picks its source lane; lanes whose source falls off the
  // end either wrap around (rotate) or take the fill value for that side.
  always_comb begin
    int s;
    s = int'(i_step);
    o_shifted = '0;
    for (int i = 0; i < NUMLANES; i++) begin
      if (i_dirLeft) begin
        if (i >= s) begin
          o_shifted[i*WIDTH +: WIDTH] = i_data[(i - s)*WIDTH +: WIDTH];
        end else if (i_rotate) begin
          o_shifted[i*WIDTH +: WIDTH] = i_data[(NUMLANES - s + i)*WIDTH +: WIDTH];
        end else begin
          o_shifted[i*WIDTH +: WIDTH] = i_fillRight;
        end
      end else begin
        if (i + s < NUMLANES) begin
          o_shifted[i*WIDTH +: WIDTH] = i_data[(i + s)*WIDTH +: WIDTH];
        end else if (i_rotate) begin
          o_shifted[i*WIDTH +: WIDTH] = i_data[(i + s - NUMLANES)*WIDTH +: WIDTH];
        end else begin
          o_shifted[i*WIDTH +: WIDTH] = i_fillLeft;
        end
      end
    end
  end

endmodule

// File: rtl/velmshifter_multijump.sv
// Multi-cycle vector element shifter: moves lanes by 0..NUMLANES-1 positions,
// at most MAXJUMP lanes per clock, with rotate/fill, squash-on-load and a
// busy/done handshake.
// Ports:
//   clk, resetn    clock and asynchronous reset (resetn=1 means reset)
//   load           parallel load of inpipe (squashed lanes zeroed), aborts a shift
//   start          request a shift of 'amount' lanes; ignored while busy
//   amount         shift distance in lanes
//   dir_left       1 = toward higher lanes; latched at start
//   rotate         1 = wrap end-around; latched at start
//   squash         per-lane zero mask applied during load
//   shiftin_left   fill entering the top lane on right shifts (sampled per step)
//   shiftin_right  fill entering lane 0 on left shifts (sampled per step)
//   inpipe         load data
//   outpipe        register contents
//   busy           a multi-step sequence is in progress
//   done           one-cycle pulse after the final step edge
module velmshifter_multijump
  import vshift_pkg::*;
#(
  parameter int NUMLANES = DEF_NUMLANES,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAXJUMP  = DEF_MAXJUMP,
  parameter int AMTBITS  = clog2(NUMLANES)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      load,
  input  logic                      start,
  input  logic [AMTBITS-1:0]        amount,
  input  logic                      dir_left,
  input  logic                      rotate,
  input  logic [NUMLANES-1:0]       squash,
  input  logic [WIDTH-1:0]          shiftin_left,
  input  logic [WIDTH-1:0]          shiftin_right,
  input  logic [NUMLANES*WIDTH-1:0] inpipe,
  output logic [NUMLANES*WIDTH-1:0] outpipe,
  output logic                      busy,
  output logic                      done
);

  localparam logic [AMTBITS-1:0] MAXJ = AMTBITS'(MAXJUMP);

  state_t                    r_state;
  logic [AMTBITS-1:0]        r_remaining;
  logic                      r_dirLeft;
  logic                      r_rotate;
  logic                      r_done;
  logic [NUMLANES*WIDTH-1:0] r_data;

  state_t                    w_nextState;
  logic [AMTBITS-1:0]        w_nextRemaining;
  logic                      w_nextDirLeft;
  logic                      w_nextRotate;
  logic                      w_nextDone;
  logic                      w_doShift;
  logic [AMTBITS-1:0]        w_step;
  logic                      w_stepDir;
  logic                      w_stepRot;
  logic [NUMLANES*WIDTH-1:0] w_shifted;
  logic [NUMLANES*WIDTH-1:0] w_loadData;

  // Load data with squashed lanes forced to zero.
  always_comb begin
    w_loadData = inpipe;
    for (int i = 0; i < NUMLANES; i++) begin
      if (squash[i]) begin
        w_loadData[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // Sequencer next-state. An accepted start performs its first step on the
  // same edge using the live dir/rotate inputs, so a short shift never enters
  // SHIFT. Load overrides everything and cancels the pending done.
  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    w_nextDirLeft   = r_dirLeft;
    w_nextRotate    = r_rotate;
    w_nextDone      = 1'b0;
    w_doShift       = 1'b0;
    w_step          = '0;
    w_stepDir       = r_dirLeft;
    w_stepRot       = r_rotate;
    if (load) begin
      w_nextState     = IDLE;
      w_nextRemaining = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_nextDirLeft = dir_left;
            w_nextRotate  = rotate;
            w_stepDir     = dir_left;
            w_stepRot     = rotate;
            w_step        = (amount > MAXJ) ? MAXJ : amount;
            w_doShift     = (amount != '0);
            w_nextRemaining = amount - w_step;
            if (w_nextRemaining != '0) begin
              w_nextState = SHIFT;
            end else begin
              w_nextDone = 1'b1;
            end
          end
        end
        SHIFT: begin
          w_step          = (r_remaining > MAXJ) ? MAXJ : r_remaining;
          w_doShift       = 1'b1;
          w_nextRemaining = r_remaining - w_step;
          if (w_nextRemaining == '0) begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  velmshift_step #(
    .NUMLANES(NUMLANES),
    .WIDTH   (WIDTH),
    .AMTBITS (AMTBITS)
  ) u_step (
    .i_data     (r_data),
    .i_step     (w_step),
    .i_dirLeft  (w_stepDir),
    .i_rotate   (w_stepRot),
    .i_fillLeft (shiftin_left),
    .i_fillRight(shiftin_right),
    .o_shifted  (w_shifted)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_dirLeft   <= 1'b0;
      r_rotate    <= 1'b0;
      r_done      <= 1'b0;
      r_data      <= '0;
    end else begin
      r_state     <= w_nextState;
      r_remaining <= w_nextRemaining;
      r_dirLeft   <= w_nextDirLeft;
      r_rotate    <= w_nextRotate;
      r_done      <= w_nextDone;
      if (load) begin
        r_data <= w_loadData;
      end else if (w_doShift) begin
        r_data <= w_shifted;
      end
    end
  end

  assign outpipe = r_data;
  assign busy    = (r_state == SHIFT);
  assign done    = r_done;

endmodule

// File: tb/tb_velmshifter_multijump.sv
// Self-checking bench for velmshifter_multijump. The reference model keeps the
// lanes in a queue and moves them one lane at a time, so a k-lane shift is k
// single-lane queue operations regardless of how the DUT batches its steps.
module tb_velmshifter_multijump;

  localparam int NL = 8;
  localparam int W  = 32;
  localparam int AB = 3;
  localparam int MJ = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            load;
  logic            start;
  logic [AB-1:0]   amount;
  logic            dir_left;
  logic            rotate;
  logic [NL-1:0]   squash;
  logic [W-1:0]    shiftin_left;
  logic [W-1:0]    shiftin_right;
  logic [NL*W-1:0] inpipe;
  logic [NL*W-1:0] outpipe;
  logic            busy;
  logic            done;

  int checkCount = 0;
  int errorCount = 0;
  logic [W-1:0] modelQ[$];

  velmshifter_multijump #(
    .NUMLANES(NL),
    .WIDTH   (W),
    .MAXJUMP (MJ),
    .AMTBITS (AB)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .start        (start),
    .amount       (amount),
    .dir_left     (dir_left),
    .rotate       (rotate),
    .squash       (squash),
    .shiftin_left (shiftin_left),
    .shiftin_right(shiftin_right),
    .inpipe       (inpipe),
    .outpipe      (outpipe),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [NL*W-1:0] observed,
                             input logic [NL*W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [NL*W-1:0] modelVector();
    logic [NL*W-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) v[i*W +: W] = modelQ[i];
    return v;
  endfunction

  function automatic logic [NL*W-1:0] countingVector(input int base);
    logic [NL*W-1:0] v;
    for (int i = 0; i < NL; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  // Move the model one lane at a time; queue index 0 is lane 0.
  task automatic modelShift(input int k, input bit left, input bit rot,
                            input logic [W-1:0] fillR, input logic [W-1:0] fillL);
    logic [W-1:0] lane;
    repeat (k) begin
      if (left) begin
        lane = modelQ.pop_back();
        modelQ.push_front(rot ? lane : fillR);
      end else begin
        lane = modelQ.pop_front();
        modelQ.push_back(rot ? lane : fillL);
      end
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic doLoad(input logic [NL*W-1:0] data, input logic [NL-1:0] sq);
    inpipe = data;
    squash = sq;
    load   = 1'b1;
    stepClock();
    load = 1'b0;
    modelQ.delete();
    for (int i = 0; i < NL; i++) modelQ.push_back(sq[i] ? '0 : data[i*W +: W]);
    checkOutput("load data", outpipe, modelVector());
    checkOutput("load done", {255'b0, done}, '0);
  endtask

  // Runs one whole shift sequence and checks busy, latency and data.
  // Returns in the done cycle so a back-to-back start can follow.
  task automatic applyStimulus(input int k, input bit left, input bit rot,
                               input logic [W-1:0] fillR, input logic [W-1:0] fillL,
                               input string tag);
    int edges;
    int expEdges;
    amount        = AB'(k);
    dir_left      = left;
    rotate        = rot;
    shiftin_right = fillR;
    shiftin_left  = fillL;
    start         = 1'b1;
    stepClock();
    start    = 1'b0;
    edges    = 1;
    expEdges = (k == 0) ? 1 : (k + MJ - 1) / MJ;
    checkOutput({tag, " busy"}, {255'b0, busy}, {255'b0, (k > MJ)});
    while (!done && edges < 20) begin
      stepClock();
      edges++;
    end
    checkOutput({tag, " latency"}, edges, expEdges);
    modelShift(k, left, rot, fillR, fillL);
    checkOutput({tag, " data"}, outpipe, modelVector());
  endtask

  initial begin
    logic [NL*W-1:0] rnd;
    int edges;
    resetn = 1'b1;
    load = 1'b0; start = 1'b0; amount = '0; dir_left = 1'b0; rotate = 1'b0;
    squash = '0; shiftin_left = '0; shiftin_right = '0; inpipe = '0;
    #12;
    checkOutput("reset outpipe", outpipe, '0);
    checkOutput("reset busy", {255'b0, busy}, '0);
    checkOutput("reset done", {255'b0, done}, '0);
    @(negedge clk);
    resetn = 1'b0;
    stepClock();

    // Left fill by 3.
    doLoad(countingVector(1), '0);
    applyStimulus(3, 1'b1, 1'b0, 32'hAA, 32'h55, "left fill 3");
    stepClock();
    checkOutput("done single pulse", {255'b0, done}, '0);

    // Right rotate by 5, zero shift, max left rotate.
    doLoad(countingVector(1), '0);
    applyStimulus(5, 1'b0, 1'b1, 32'h0, 32'h0, "right rot 5");
    stepClock();
    doLoad(countingVector(1), '0);
    applyStimulus(0, 1'b1, 1'b0, 32'h77, 32'h77, "zero shift");
    stepClock();
    applyStimulus(7, 1'b1, 1'b1, 32'h0, 32'h0, "left rot 7");
    stepClock();

    // Load aborts an ongoing sequence; squashed lane 2 becomes zero.
    doLoad(countingVector(1), '0);
    amount = 3'd7; dir_left = 1'b1; rotate = 1'b1; start = 1'b1;
    stepClock();
    start = 1'b0;
    checkOutput("abort busy before", {255'b0, busy}, {255'b0, 1'b1});
    doLoad(countingVector(16), 8'b0000_0100);
    checkOutput("abort busy after", {255'b0, busy}, '0);
    stepClock();
    checkOutput("abort no done", {255'b0, done}, '0);

    // Start while busy is ignored; start in the done cycle is accepted.
    doLoad(countingVector(1), '0);
    amount = 3'd5; dir_left = 1'b0; rotate = 1'b0; shiftin_left = 32'hBB; start = 1'b1;
    stepClock();
    amount = 3'd1; dir_left = 1'b1; rotate = 1'b1;
    stepClock();
    start = 1'b0;
    edges = 2;
    while (!done && edges < 20) begin
      stepClock();
      edges++;
    end
    checkOutput("busy start latency", edges, 3);
    modelShift(5, 1'b0, 1'b0, 32'h0, 32'hBB);
    checkOutput("busy start data", outpipe, modelVector());
    applyStimulus(2, 1'b1, 1'b0, 32'hCC, 32'h0, "back to back");
    stepClock();

    // Asynchronous reset in the middle of a sequence, no clock edge needed.
    doLoad(countingVector(1), '0);
    amount = 3'd7; dir_left = 1'b0; rotate = 1'b1; start = 1'b1;
    stepClock();
    start = 1'b0;
    #2;
    resetn = 1'b1;
    #1;
    checkOutput("async reset outpipe", outpipe, '0);
    checkOutput("async reset busy", {255'b0, busy}, '0);
    checkOutput("async reset done", {255'b0, done}, '0);
    @(negedge clk);
    resetn = 1'b0;
    stepClock();
    modelQ.delete();
    for (int i = 0; i < NL; i++) modelQ.push_back('0);

    // Randomized sequences with occasional reloads.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < NL; i++) rnd[i*W +: W] = $urandom;
        doLoad(rnd, NL'($urandom));
      end
      applyStimulus(int'($urandom_range(0, NL - 1)), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, "random");
      stepClock();
      checkOutput("random done clear", {255'b0, done}, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/velmshifter_multijump.md
Name: velmshifter_multijump

Overview:
Parametrised vector-element shifter. Moves whole lanes of a NUMLANES x WIDTH vector left or right by a requested distance of 0..NUMLANES-1 lanes. Works as a multi-cycle sequencer that advances at most MAXJUMP lanes per cycle, with optional rotate mode, per-lane squash on load, and busy/done handshake. Used by vector slide, extract and compress paths in place of the fixed shift-by-1/2 element shifters.

Parameters:
NUMLANES, 8, number of vector lanes (power of 2, >=2)
WIDTH, 32, bits per lane
MAXJUMP, 2, maximum lanes moved per cycle (power of 2, 1..NUMLANES/2)
AMTBITS, 3, width of amount port, equals log2(NUMLANES)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous reset, active-high (1 = reset) despite the name
load  in  1  load inpipe into the register, aborting any shift in progress
start  in  1  begin a shift of amount lanes; sampled only when not busy
amount  in  AMTBITS  shift distance in lanes
dir_left  in  1  1 = toward higher lanes, 0 = toward lower lanes; sampled at start
rotate  in  1  1 = wrap lanes end-around, 0 = fill; sampled at start
squash  in  NUMLANES  per-lane mask; lane i is loaded with 0 when squash[i]=1 during load
shiftin_left  in  WIDTH  fill value entering lane NUMLANES-1 on a right shift
shiftin_right  in  WIDTH  fill value entering lane 0 on a left shift
inpipe  in  NUMLANES*WIDTH  parallel load data; lane i = bits [i*WIDTH +: WIDTH]
outpipe  out  NUMLANES*WIDTH  register contents
busy  out  1  shift sequence in progress
done  out  1  one-cycle pulse: the sequence completed at the previous edge

Behaviour:
- Reset: outpipe=0, busy=0, done=0, remaining=0, FSM=IDLE. Reset asserted mid-sequence aborts immediately with no done.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- Per-edge step size: step = min(remaining, MAXJUMP).
  - Left step: lane i <= lane i-step; lanes below step get shiftin_right, or lane NUMLANES-step+i when rotating.
  - Right step: mirror image; lanes at or above NUMLANES-step get shiftin_left, or the wrapped low lanes when rotating.
- Latched at start: dir_left, rotate, and remaining=amount. Fill values are sampled live on every step.
- Start accepted in IDLE with amount=k>0: the first step happens at that same edge, and remaining becomes k-step.
  - If remaining is nonzero, go to SHIFT.
  - Otherwise stay in IDLE and set done=1 for the next cycle.
  - Total latency: ceil(k/MAXJUMP) edges. done is high in the cycle after the final step edge.
- Start with amount=0: no data change; done=1 in the next cycle.
- SHIFT: one step per edge. When remaining reaches 0, go to IDLE and set done=1. start is ignored while busy.
- Load: outpipe <= inpipe with squashed lanes zeroed; go to IDLE; busy=0; done=0.
  - Load has priority over start and over an ongoing SHIFT. The aborted sequence produces no done.
- done is registered and is never high in two consecutive cycles unless a new start was accepted in the done cycle. Start is legal in the done cycle.
- Shift arithmetic: remaining is AMTBITS wide, cannot underflow because step <= remaining, and has no wrap-around.

Decomposition:
- Shared package vshift_pkg holds:
  - FSM state encoding: IDLE=0, SHIFT=1.
  - Function clog2.
  - Lane-slice helper constants.
- One sub-module, velmshift_step: a combinational barrel stage.
  - Inputs: data, step (0..MAXJUMP), dir, rotate, fill values.
  - Output: the shifted vector.
  - Instantiated once and driven by the FSM/counter datapath in the top module.

Test Plan:
Defaults throughout; lane i preloaded to i+1 (lanes 0..7 = 1..8).
- Reset: assert resetn mid-SHIFT -> outpipe=0, busy=0, done=0 on the same cycle, with no clock needed.
- Left fill: start amount=3, dir_left=1, rotate=0, shiftin_right=0xAA -> busy=1 for 1 cycle, done at cycle 2; lanes 0..7 = AA,AA,AA,1,2,3,4,5.
- Right rotate: start amount=5, dir_left=0, rotate=1 -> 3 step edges; lanes 0..7 = 6,7,8,1,2,3,4,5; single done pulse.
- Zero and max: amount=0 -> data unchanged, done next cycle. amount=7, left rotate -> 4 edges; lanes = 2,3,4,5,6,7,8,1.
- Load abort: start amount=7, then assert load with inpipe lanes=0x10..0x17 and squash=8'b0000_0100 after 1 edge -> lanes = 10,11,0,13,14,15,16,17; busy=0; no done.
- Start while busy ignored: second start during SHIFT -> result and done timing match a single sequence; back-to-back start in the done cycle is accepted.
